mean_square: RTL and testbench

- Streaming mean-square estimator that sits directly upstream of the integer square-root stage; together they form the RMS path.
- Accepts signed samples (Q<DW>.0) qualified by a valid strobe and squares each one.
- Accumulates the squares over non-overlapping windows of 2^LOG2N accepted samples.
- At each window end, emits the floor mean of the squares as UQ<2*DW>.0, sized to drive a WIDTH = 2*DW square-root input directly.

---
 rtl/rms_pkg.sv | 22 ++
 rtl/square_reg.sv | 43 ++++
 rtl/mean_square.sv | 96 +++++++++
 tb/tb_mean_square.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rms_pkg.sv
// Shared types and width helpers for the RMS path (mean-square estimator and
// downstream stages).
package rms_pkg;

    // Widest square: DW up to 32 gives a 63-bit unsigned magnitude.
    localparam int unsigned SqMaxW = 63;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned log2n);
        return 2 * dw - 1 + log2n;
    endfunction

    function automatic int unsigned out_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [SqMaxW-1:0] sq;
    } s1_rec_t;

endpackage

// File: rtl/square_reg.sv
// Registered signed square with valid/last pass-through; the square is held
// when no sample is presented.
module square_reg
    import rms_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic          last,
    input  logic [DW-1:0] data,
    output s1_rec_t       rec
);

    logic signed [2*DW-1:0] data_ext;
    logic signed [2*DW-1:0] prod;
    s1_rec_t                rec_d, rec_q;

    assign data_ext = $signed({{DW{data[DW-1]}}, data});
    assign prod     = data_ext * data_ext;

    always_comb begin
        rec_d       = rec_q;
        rec_d.valid = valid;
        if (valid) begin
            rec_d.last = last;
            // A square is never negative, so the sign bit is always zero.
            rec_d.sq   = SqMaxW'($unsigned(prod));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec = rec_q;

endmodule

// File: rtl/mean_square.sv
// Streaming mean-square estimator: squares each accepted sample and emits the
// floor mean of the squares over non-overlapping windows of 2^LOG2N samples.
module mean_square
    import rms_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned LOG2N = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            sink_valid,
    input  logic [DW-1:0]   sink,
    output logic [2*DW-1:0] source,
    output logic            source_valid,
    output logic [LOG2N:0]  count
);

    localparam int unsigned    AccW   = acc_width(DW, LOG2N);
    localparam int unsigned    OutW   = out_width(DW);
    localparam logic [LOG2N:0] CntMax = (LOG2N + 1)'((1 << LOG2N) - 1);
    localparam logic [LOG2N:0] CntOne = (LOG2N + 1)'(1);

    s1_rec_t        s1;
    logic           last_in;
    logic [LOG2N:0] count_d, count_q;
    logic [AccW-1:0] acc_d, acc_q;
    logic [AccW-1:0] sq_ext, sum;
    logic [OutW-1:0] mean;
    logic [OutW-1:0] source_d, source_q;
    logic            source_valid_d, source_valid_q;

    // A sample arriving with clear is sample 0 of a fresh window.
    assign last_in = clear ? (LOG2N == 0) : (count_q == CntMax);

    square_reg #(
        .DW(DW)
    ) u_square_reg (
        .clk  (clk),
        .reset(reset),
        .valid(sink_valid),
        .last (last_in),
        .data (sink),
        .rec  (s1)
    );

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = (sink_valid && (LOG2N != 0)) ? CntOne : '0;
        end else if (sink_valid) begin
            count_d = (count_q == CntMax) ? '0 : count_q + CntOne;
        end
    end

    assign sq_ext = AccW'(s1.sq);
    assign sum    = acc_q + sq_ext;
    assign mean   = OutW'(sum >> LOG2N);

    // clear squashes the in-flight square, even a window-closing one.
    always_comb begin
        acc_d          = acc_q;
        source_d       = source_q;
        source_valid_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (s1.valid) begin
            if (s1.last) begin
                source_d       = mean;
                source_valid_d = 1'b1;
                acc_d          = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q        <= '0;
            acc_q          <= '0;
            source_q       <= '0;
            source_valid_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            acc_q          <= acc_d;
            source_q       <= source_d;
            source_valid_q <= source_valid_d;
        end
    end

    assign source       = source_q;
    assign source_valid = source_valid_q;
    assign count        = count_q;

endmodule

// File: tb/tb_mean_square.sv
// Bench for mean_square: directed vector table plus randomized traffic against a
// window-level reference model (DW=8, N=4), then an N=1 instance.
module tb_mean_square;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1, clear = 1'b0, sink_valid = 1'b0;
    logic [7:0]  sink = '0;
    logic [15:0] source;
    logic        source_valid;
    logic [2:0]  count;

    logic        b_reset = 1'b1, b_clear = 1'b0, b_valid = 1'b0;
    logic [7:0]  b_sink = '0;
    logic [15:0] b_source;
    logic        b_source_valid;
    logic [0:0]  b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mean_square #(.DW(8), .LOG2N(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .sink_valid  (sink_valid),
        .sink        (sink),
        .source      (source),
        .source_valid(source_valid),
        .count       (count)
    );

    mean_square #(.DW(8), .LOG2N(0)) dut_n1 (
        .clk         (clk),
        .reset       (b_reset),
        .clear       (b_clear),
        .sink_valid  (b_valid),
        .sink        (b_sink),
        .source      (b_source),
        .source_valid(b_source_valid),
        .count       (b_count)
    );

    // Reference model: a window of accepted samples closes after N of them and
    // its floor mean appears on the following edge unless clear/reset intervene.
    int     m_cnt = 0;
    longint m_sum = 0;
    bit     m_pend = 0;
    longint m_pend_val = 0;
    longint m_src = 0;
    bit     m_sv = 0;

    task automatic model_step(input bit r, input bit c, input bit v, input int s);
        if (r) begin
            m_cnt = 0; m_sum = 0; m_pend = 0; m_src = 0; m_sv = 0;
        end else begin
            if (c) begin
                m_sv = 0; m_pend = 0; m_cnt = 0; m_sum = 0;
            end else begin
                m_sv = m_pend;
                if (m_pend) m_src = m_pend_val;
                m_pend = 0;
            end
            if (v) begin
                m_sum += longint'(s) * longint'(s);
                m_cnt++;
                if (m_cnt == N) begin
                    m_pend = 1;
                    m_pend_val = m_sum / N;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input int s);
        @(negedge clk);
        reset = r; clear = c; sink_valid = v; sink = s[7:0];
        @(posedge clk);
        #1;
        model_step(r, c, v, s);
    endtask

    task automatic check_model(input string tag);
        check({tag, " source"}, longint'(source), m_src);
        check({tag, " source_valid"}, longint'(source_valid), longint'(m_sv));
        check({tag, " count"}, longint'(count), longint'(m_cnt));
    endtask

    typedef struct {
        bit rst; bit clr; bit vld; int smp;
        int e_src; bit e_sv; int e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit c, input bit v, input int s,
                       input int es, input bit ev, input int ec);
        vec_t t;
        t.rst = r; t.clr = c; t.vld = v; t.smp = s;
        t.e_src = es; t.e_sv = ev; t.e_cnt = ec;
        tbl.push_back(t);
    endtask

    task automatic step_b(input bit r, input bit c, input bit v, input int s,
                          input int es, input bit ev, input string name);
        @(negedge clk);
        b_reset = r; b_clear = c; b_valid = v; b_sink = s[7:0];
        @(posedge clk);
        #1;
        check({name, " source"}, longint'(b_source), longint'(es));
        check({name, " source_valid"}, longint'(b_source_valid), longint'(ev));
        check({name, " count"}, longint'(b_count), 0);
    endtask

    initial begin
        // reset
        add(1, 0, 0, 0,       0, 0, 0);
        // 3,-4,5,-6 -> 86/4 = 21
        add(0, 0, 1, 3,       0, 0, 1);
        add(0, 0, 1, -4,      0, 0, 2);
        add(0, 0, 1, 5,       0, 0, 3);
        add(0, 0, 1, -6,      0, 0, 0);
        add(0, 0, 0, 0,      21, 1, 0);
        add(0, 0, 0, 0,      21, 0, 0);
        // full-scale negative then back-to-back 127s
        add(0, 0, 1, -128,   21, 0, 1);
        add(0, 0, 1, -128,   21, 0, 2);
        add(0, 0, 1, -128,   21, 0, 3);
        add(0, 0, 1, -128,   21, 0, 0);
        add(0, 0, 1, 127, 16384, 1, 1);
        add(0, 0, 1, 127, 16384, 0, 2);
        add(0, 0, 1, 127, 16384, 0, 3);
        add(0, 0, 1, 127, 16384, 0, 0);
        add(0, 0, 0, 0,   16129, 1, 0);
        // clear with a sample restarts the window
        add(0, 0, 1, 1,   16129, 0, 1);
        add(0, 0, 1, 2,   16129, 0, 2);
        add(0, 1, 1, 10,  16129, 0, 1);
        add(0, 0, 1, 10,  16129, 0, 2);
        add(0, 0, 1, 10,  16129, 0, 3);
        add(0, 0, 1, 10,  16129, 0, 0);
        add(0, 0, 0, 0,     100, 1, 0);
        // clear right after the closing sample squashes the pulse
        add(0, 0, 1, 1,     100, 0, 1);
        add(0, 0, 1, 1,     100, 0, 2);
        add(0, 0, 1, 1,     100, 0, 3);
        add(0, 0, 1, 1,     100, 0, 0);
        add(0, 1, 0, 0,     100, 0, 0);
        add(0, 0, 0, 0,     100, 0, 0);
        // 0..7 with gaps -> 3 then 31
        add(0, 0, 1, 0,     100, 0, 1);
        add(0, 0, 0, 0,     100, 0, 1);
        add(0, 0, 1, 1,     100, 0, 2);
        add(0, 0, 1, 2,     100, 0, 3);
        add(0, 0, 0, 0,     100, 0, 3);
        add(0, 0, 1, 3,     100, 0, 0);
        add(0, 0, 1, 4,       3, 1, 1);
        add(0, 0, 0, 0,       3, 0, 1);
        add(0, 0, 1, 5,       3, 0, 2);
        add(0, 0, 1, 6,       3, 0, 3);
        add(0, 0, 0, 0,       3, 0, 3);
        add(0, 0, 1, 7,       3, 0, 0);
        add(0, 0, 0, 0,      31, 1, 0);
        add(0, 0, 0, 0,      31, 0, 0);
        // reset mid-window (with a sample present) leaves no carry-over
        add(0, 0, 1, 2,      31, 0, 1);
        add(0, 0, 1, 2,      31, 0, 2);
        add(1, 0, 1, 9,       0, 0, 0);
        add(0, 0, 1, 2,       0, 0, 1);
        add(0, 0, 1, 2,       0, 0, 2);
        add(0, 0, 1, 2,       0, 0, 3);
        add(0, 0, 1, 2,       0, 0, 0);
        add(0, 0, 0, 0,       4, 1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].smp);
            check($sformatf("vec%0d source", i), longint'(source), longint'(tbl[i].e_src));
            check($sformatf("vec%0d source_valid", i), longint'(source_valid),
                  longint'(tbl[i].e_sv));
            check($sformatf("vec%0d count", i), longint'(count), longint'(tbl[i].e_cnt));
            check_model($sformatf("vec%0d model", i));
        end

        for (int i = 0; i < 600; i++) begin
            bit r, c, v;
            int s;
            r = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = int'($signed(8'($urandom_range(0, 255))));
            step(r, c, v, s);
            check_model($sformatf("rnd%0d", i));
        end

        @(negedge clk);
        reset = 1'b0; clear = 1'b0; sink_valid = 1'b0;

        // N = 1: every accepted sample is its own window
        step_b(1, 0, 0, 0,    0, 0, "n1 reset");
        step_b(0, 0, 1, 5,    0, 0, "n1 s5");
        step_b(0, 0, 1, -7,  25, 1, "n1 s-7");
        step_b(0, 0, 0, 0,   49, 1, "n1 idle0");
        step_b(0, 0, 0, 0,   49, 0, "n1 idle1");
        step_b(0, 0, 1, 3,   49, 0, "n1 s3");
        step_b(0, 1, 0, 0,   49, 0, "n1 clr squash");
        step_b(0, 1, 1, 4,   49, 0, "n1 clr s4");
        step_b(0, 0, 0, 0,   16, 1, "n1 idle2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
